// File: rtl/dsp_sys_arr_pkg.sv
// Shared types and defaults for the DSP systolic-array front end.
// Provides the stream word type and FIFO sizing helpers.
package dsp_sys_arr_pkg;

  localparam int WORD_W              = 16;
  localparam int DEFAULT_FIFO_DEPTH  = 4;
  localparam int DEFAULT_FRAME_BEATS = 8;

  typedef logic [WORD_W-1:0] word_t;

  // Occupancy needs one extra bit so that "full" (== depth) is representable.
  function automatic int fifo_level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [fifo_level_w(DEFAULT_FIFO_DEPTH)-1:0] fifo_level_t;

endpackage

// File: rtl/axis_proto_chk.sv
// Upstream AXI-stream rule checker: once a beat is stalled, valid and data must hold.
// Instantiated by axis_beat_fifo only when AXIS_PROTO_CHECK_EN is defined.
module axis_proto_chk
  import dsp_sys_arr_pkg::*;
#(
  parameter int BW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic           in_ready,
  input  word_t [BW-1:0] in_stream,
  output logic           err
);

  logic           r_stall;
  word_t [BW-1:0] r_stream;
  logic           r_err;
  logic           w_viol;

  assign w_viol = r_stall && (!in_valid || (in_stream != r_stream));
  assign err    = r_err;

  // Remember last cycle's stall and data; the error flag is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall  <= 1'b0;
      r_stream <= '0;
      r_err    <= 1'b0;
    end else begin
      r_stall  <= in_valid && !in_ready;
      r_stream <= in_stream;
      r_err    <= r_err || w_viol;
    end
  end

endmodule

// File: rtl/axis_beat_fifo.sv
// In-order AXI-stream beat buffer with per-frame done pulse on the output side.
// Define AXIS_PROTO_CHECK_EN to compile in the upstream protocol checker driving err.
module axis_beat_fifo
  import dsp_sys_arr_pkg::*;
#(
  parameter int BW          = 2,
  parameter int DEPTH       = DEFAULT_FIFO_DEPTH,
  parameter int FRAME_BEATS = DEFAULT_FRAME_BEATS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  word_t [BW-1:0]                 in_stream,
  output logic                           out_valid,
  input  logic                           out_ready,
  output word_t [BW-1:0]                 out_stream,
  output logic                           done,
  output logic                           err,
  output logic [fifo_level_w(DEPTH)-1:0] level
);

  localparam int AW  = $clog2(DEPTH);
  localparam int BCW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

  localparam logic [AW:0]    LVL_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]    LVL_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0]  PTR_ONE   = AW'(1);
  localparam logic [BCW-1:0] BEAT_LAST = BCW'(FRAME_BEATS - 1);
  localparam logic [BCW-1:0] BEAT_ONE  = BCW'(1);

  word_t [BW-1:0] r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_level;
  logic [BCW-1:0] r_beat;
  logic           r_done;
  logic           w_push;
  logic           w_pop;
  logic           w_err;

  // Ready/valid depend only on registered occupancy, so a pop never frees space same-cycle.
  assign in_ready  = (r_level != LVL_FULL);
  assign out_valid = (r_level != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign level     = r_level;
  assign done      = r_done;
  assign err       = w_err;

  always_comb begin
    out_stream = '0;
    if (out_valid) begin
      out_stream = r_mem[r_rd_ptr];
    end else begin
      out_stream = '0;
    end
  end

  // Beat storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_stream;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_beat   <= '0;
      r_done   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
      if (w_pop) begin
        if (r_beat == BEAT_LAST) begin
          r_beat <= '0;
        end else begin
          r_beat <= r_beat + BEAT_ONE;
        end
      end
      r_done <= w_pop && (r_beat == BEAT_LAST);
    end
  end

`ifdef AXIS_PROTO_CHECK_EN
  axis_proto_chk #(
    .BW(BW)
  ) u_proto_chk (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_stream(in_stream),
    .err      (w_err)
  );
`else
  assign w_err = 1'b0;
`endif

endmodule

// File: doc/axis_beat_fifo.md
# axis_beat_fifo

Parametrised AXI-stream buffer between the host stream front end and the DSP systolic array: accepts beats of BW words, stores up to DEPTH beats, and re-emits them in order with independent input/output backpressure. It counts output beats per frame and raises `done` at each frame boundary. An optional protocol checker flags upstream valid/data violations on `err`. Its stream ports match the slave modport of `AXI_STREAM_if #(BW)`.

## Interface
- BW, 2, words per beat (≥1)
- DEPTH, 4, beats of storage (power of two, ≥2)
- FRAME_BEATS, 8, output beats per frame (≥1)
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream beat valid
- in_ready  out  1  buffer can accept a beat
- in_stream  in  BW×word_t  upstream beat
- out_valid  out  1  head beat available
- out_ready  in  1  downstream accepts
- out_stream  out  BW×word_t  head beat
- done  out  1  one-cycle pulse when a frame completes
- err  out  1  sticky protocol-violation flag
- level  out  $clog2(DEPTH)+1  beats stored

## Operation
- Push on in_valid && in_ready; pop on out_valid && out_ready; both may occur in the same cycle.
- in_ready = (level != DEPTH), combinational from registered state; a pop does not open space in the same cycle.
- out_valid = (level != 0); out_stream = mem[rd_ptr] when out_valid, else all zeros.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0; level counts 0..DEPTH, +1 on push only, -1 on pop only, unchanged on both or neither.
- Beat counter 0..FRAME_BEATS-1 increments on each pop; on the pop that completes beat FRAME_BEATS-1 it returns to 0 and done pulses high for the next cycle.
- Reset (any cycle, including mid-frame or while full): pointers, level, beat counter, done and err go to 0; in_ready=1, out_valid=0, out_stream=0. Memory contents are not reset, and stored beats are discarded.

## Timing
- Latency: a beat pushed at edge N is visible with out_valid=1 after edge N; minimum one cycle in to out.
- Throughput: one beat per cycle in steady state when 0<level<DEPTH.
- Full with in_valid=1 and pop: pop occurs, push refused; in_ready=1 next cycle.
- Empty with push and out_ready=1: no pop in that cycle (out_valid=0).
- done is registered, asserted exactly one cycle after the final-beat handshake edge.

## Configuration
- AXIS_PROTO_CHECK_EN defined: checker compiled in. err sets, and stays set until rst, when in_valid was 1 and in_ready was 0 in the previous cycle and either (a) in_valid is now 0, or (b) in_stream differs from its previous-cycle value. Data path behaviour is unchanged.
- Undefined: no checker logic; err tied to 0.

## Structure
- dsp_sys_arr_pkg provides word_t; add fifo_level_t helper width and default FIFO_DEPTH / FRAME_BEATS constants there.
- Sub-module axis_proto_chk (clk, rst, in_valid, in_ready, in_stream -> err), instantiated only under AXIS_PROTO_CHECK_EN.

## Test plan
- Reset then idle: in_ready=1, out_valid=0, level=0, out_stream=0, done=0, err=0.
- DEPTH=4, push 4 beats {1,2},{3,4},{5,6},{7,8} with out_ready=0 -> level=4, in_ready=0; fifth beat refused; release out_ready -> beats emerge in order, in_ready returns 1 cycle after first pop.
- Continuous in_valid=out_ready=1 for 20 beats, FRAME_BEATS=8 -> 1 beat/cycle, done pulses after output beats 8 and 16 only.
- Full plus simultaneous pop/push attempt -> pop taken, push refused, level 4→3.
- rst asserted mid-frame with level=3 -> all outputs at reset values; next frame's done pulses after 8 fresh beats.
- With AXIS_PROTO_CHECK_EN, hold full, change in_stream while in_valid=1 -> err=1 and stays 1 until rst; without the macro, err stays 0.
